ip_top_align_core: RTL and testbench

//  Core of the word-aligned memory: maps a narrow logical port (one WIDTH word/access) onto a wide

---
 rtl/ip_top_align_core.sv | 128 ++++++++++++
 tb/tb_ip_top_align_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ip_top_align_core.sv
// rtl/ip_top_align_core.sv - narrow logical word port mapped onto wide single-port SRAM rows
module ip_top_align_core #(
  parameter int WIDTH      = 32,
  parameter int PARITY     = 1,
  parameter int NUMADDR    = 1024,
  parameter int BITADDR    = 10,
  parameter int NUMWRDS    = 4,
  parameter int BITWRDS    = 2,
  parameter int NUMSROW    = 256,
  parameter int BITSROW    = 8,
  parameter int SRAM_DELAY = 2,
  parameter int MEMWDTH    = WIDTH + PARITY
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         read,
  input  logic                         write,
  input  logic [BITADDR-1:0]           addr,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         serr,
  output logic [BITWRDS+BITSROW-1:0]   padr,
  output logic                         rd_vld,
  output logic [15:0]                  serr_cnt,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [BITSROW-1:0]           mem_addr,
  output logic [NUMWRDS*MEMWDTH-1:0]   mem_bw,
  output logic [NUMWRDS*MEMWDTH-1:0]   mem_din,
  input  logic [NUMWRDS*MEMWDTH-1:0]   mem_dout
);
  // A one-word row still needs a 1-bit select internally; it is simply always zero.
  localparam int WSELW = (BITWRDS > 0) ? BITWRDS : 1;

  logic [31:0]         addr_ext;
  logic                legal;
  logic [WSELW-1:0]    req_word;
  logic [BITSROW-1:0]  req_row;
  logic [MEMWDTH-1:0]  wr_slot;

  assign addr_ext = 32'(addr);
  assign legal    = (addr_ext < 32'(NUMADDR)) && ((addr_ext / 32'(NUMWRDS)) < 32'(NUMSROW));
  assign req_word = WSELW'(addr_ext % 32'(NUMWRDS));
  assign req_row  = BITSROW'(addr_ext / 32'(NUMWRDS));

  generate
    if (PARITY != 0) begin : g_par
      assign wr_slot = {^din, din};
    end else begin : g_nopar
      assign wr_slot = din;
    end
  endgenerate

  // Write wins over a simultaneous read so the SRAM never sees both enables.
  always_comb begin
    mem_write = rst_n && legal && write;
    mem_read  = rst_n && legal && read && !write;
    mem_addr  = (mem_write || mem_read) ? req_row : '0;
    mem_bw    = '0;
    mem_din   = '0;
    if (mem_write) begin
      for (int w = 0; w < NUMWRDS; w++) begin
        mem_din[w*MEMWDTH +: MEMWDTH] = wr_slot;
        if (req_word == WSELW'(w)) mem_bw[w*MEMWDTH +: MEMWDTH] = '1;
      end
    end
  end

  logic [SRAM_DELAY-1:0] pipe_vld;
  logic [WSELW-1:0]      pipe_word [SRAM_DELAY];
  logic [BITSROW-1:0]    pipe_row  [SRAM_DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < SRAM_DELAY; i++) begin
        pipe_word[i] <= '0;
        pipe_row[i]  <= '0;
      end
    end else begin
      pipe_vld[0]  <= mem_read;
      pipe_word[0] <= mem_read ? req_word : '0;
      pipe_row[0]  <= mem_read ? req_row  : '0;
      for (int i = 1; i < SRAM_DELAY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_word[i] <= pipe_word[i-1];
        pipe_row[i]  <= pipe_row[i-1];
      end
    end
  end

  logic [WSELW-1:0]   out_word;
  logic [BITSROW-1:0] out_row;
  logic [MEMWDTH-1:0] out_slot;
  logic               dout_serr_mask;

  assign rd_vld   = pipe_vld[SRAM_DELAY-1];
  assign out_word = pipe_word[SRAM_DELAY-1];
  assign out_row  = pipe_row[SRAM_DELAY-1];

  always_comb begin
    out_slot = '0;
    for (int w = 0; w < NUMWRDS; w++) begin
      if (out_word == WSELW'(w)) out_slot = mem_dout[w*MEMWDTH +: MEMWDTH];
    end
  end

  assign dout           = rd_vld ? out_slot[WIDTH-1:0] : '0;
  assign dout_serr_mask = rd_vld && (PARITY != 0) && (^out_slot);
  assign serr           = dout_serr_mask;

  generate
    if (BITWRDS > 0) begin : g_padr_ws
      assign padr = rd_vld ? {out_word, out_row} : '0;
    end else begin : g_padr_row
      assign padr = rd_vld ? out_row : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serr_cnt <= '0;
    end else if (serr && (serr_cnt != 16'hFFFF)) begin
      serr_cnt <= serr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ip_top_align_core.sv
// tb/tb_ip_top_align_core.sv - directed self-checking bench for ip_top_align_core
module tb_ip_top_align_core;
  localparam int W   = 32;
  localparam int NW  = 4;
  localparam int MW  = 33;
  localparam int RW  = NW * MW;
  localparam int NRW = NW * W;
  localparam int BA  = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [BA-1:0] addr = '0;
  logic [W-1:0]  din = '0;

  logic [W-1:0]  dout;
  logic          serr;
  logic [9:0]    padr;
  logic          rd_vld;
  logic [15:0]   serr_cnt;
  logic          mem_read, mem_write;
  logic [7:0]    mem_addr;
  logic [RW-1:0] mem_bw, mem_din;
  logic [RW-1:0] mem_dout = '0;

  logic [W-1:0]   np_dout;
  logic           np_serr;
  logic [9:0]     np_padr;
  logic           np_rd_vld;
  logic [15:0]    np_serr_cnt;
  logic           np_mem_read, np_mem_write;
  logic [7:0]     np_mem_addr;
  logic [NRW-1:0] np_mem_bw, np_mem_din, np_mem_dout;

  int checks = 0;
  int errors = 0;

  logic          sram_clr = 1'b1;
  logic          flip_en = 1'b0;
  logic [7:0]    flip_row = '0;
  int            flip_bit = 0;
  logic [RW-1:0] sram [256];
  logic [RW-1:0] rd_p1 = '0;

  always #5 clk = ~clk;

  ip_top_align_core #(.BITADDR(BA)) u_dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .din(din),
    .dout(dout), .serr(serr), .padr(padr), .rd_vld(rd_vld), .serr_cnt(serr_cnt),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_bw(mem_bw), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  ip_top_align_core #(.BITADDR(BA), .PARITY(0)) u_dut_np (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .din(din),
    .dout(np_dout), .serr(np_serr), .padr(np_padr), .rd_vld(np_rd_vld), .serr_cnt(np_serr_cnt),
    .mem_read(np_mem_read), .mem_write(np_mem_write), .mem_addr(np_mem_addr),
    .mem_bw(np_mem_bw), .mem_din(np_mem_din), .mem_dout(np_mem_dout)
  );

  // Two-cycle SRAM: address captured on the edge of the read, data presented one edge later.
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int r = 0; r < 256; r++) sram[r] <= '0;
    end else begin
      if (mem_write) sram[mem_addr] <= (sram[mem_addr] & ~mem_bw) | (mem_din & mem_bw);
      if (flip_en) sram[flip_row][flip_bit] <= ~sram[flip_row][flip_bit];
    end
    if (mem_read) rd_p1 <= sram[mem_addr];
    mem_dout <= rd_p1;
  end

  always_comb begin
    np_mem_dout = '0;
    for (int w = 0; w < NW; w++) np_mem_dout[w*W +: W] = mem_dout[w*MW +: W];
  end

  task automatic check_val(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] t2_data(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic exp_v;
    int   j;

    // reset: a read request must not reach the SRAM and all outputs stay quiet
    read = 1'b1; addr = 11'd3;
    @(negedge clk); #1;
    check_val("rst_rd_vld", rd_vld, 1'b0);
    check_val("rst_dout", dout, 32'h0);
    check_val("rst_serr", serr, 1'b0);
    check_val("rst_padr", padr, 10'h0);
    check_val("rst_serr_cnt", serr_cnt, 16'h0);
    check_val("rst_mem_read", mem_read, 1'b0);
    @(negedge clk); rst_n = 1'b1; sram_clr = 1'b0; read = 1'b0;

    // 1: write addr 5 then read it back next cycle
    @(negedge clk); write = 1'b1; addr = 11'd5; din = 32'hA5A5_0001; #1;
    check_val("t1_mem_write", mem_write, 1'b1);
    check_val("t1_mem_read", mem_read, 1'b0);
    check_val("t1_mem_addr", mem_addr, 8'd1);
    check_val("t1_mem_bw", mem_bw, {33'h0, 33'h0, {33{1'b1}}, 33'h0});
    check_val("t1_mem_din", mem_din, {4{33'h1_A5A5_0001}});
    check_val("t1_np_mem_din", np_mem_din, {4{32'hA5A5_0001}});
    @(negedge clk); write = 1'b0; read = 1'b1; #1;
    check_val("t1_rd_mem_read", mem_read, 1'b1);
    check_val("t1_rd_mem_addr", mem_addr, 8'd1);
    check_val("t1_rd_mem_bw", mem_bw, '0);
    @(negedge clk); read = 1'b0; #1;
    check_val("t1_early_vld", rd_vld, 1'b0);
    @(negedge clk); #1;
    check_val("t1_rd_vld", rd_vld, 1'b1);
    check_val("t1_dout", dout, 32'hA5A5_0001);
    check_val("t1_serr", serr, 1'b0);
    check_val("t1_padr", padr, 10'h101);
    @(negedge clk); #1;
    check_val("t1_vld_drop", rd_vld, 1'b0);

    // 2: fill addr 0..7, then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); write = 1'b1; addr = 11'(i); din = t2_data(i);
    end
    @(negedge clk); write = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      read = (i < 8); addr = 11'(i);
      #1;
      exp_v = (i >= 2) && (i < 10);
      j = i - 2;
      check_val("t2_rd_vld", rd_vld, exp_v);
      if (exp_v) begin
        check_val("t2_padr", padr, {2'(j % 4), 8'(j / 4)});
        check_val("t2_dout", dout, t2_data(j));
      end
    end
    read = 1'b0;

    // 3: corrupt one stored bit of addr 12 (row 3, slot 0, bit 3)
    @(negedge clk); write = 1'b1; addr = 11'd12; din = 32'h0000_00F0;
    @(negedge clk); write = 1'b0; flip_en = 1'b1; flip_row = 8'd3; flip_bit = 3;
    @(negedge clk); flip_en = 1'b0; #1;
    check_val("t3_cnt_before", serr_cnt, 16'h0);
    @(negedge clk); read = 1'b1; addr = 11'd12;
    @(negedge clk); read = 1'b0;
    @(negedge clk); #1;
    check_val("t3_rd_vld", rd_vld, 1'b1);
    check_val("t3_serr", serr, 1'b1);
    check_val("t3_dout", dout, 32'h0000_00F8);
    check_val("t3_padr", padr, 10'h003);
    check_val("t3_cnt_same_cycle", serr_cnt, 16'h0);
    check_val("t3_np_rd_vld", np_rd_vld, 1'b1);
    check_val("t3_np_serr", np_serr, 1'b0);
    check_val("t3_np_dout", np_dout, 32'h0000_00F8);
    @(negedge clk); #1;
    check_val("t3_cnt_after", serr_cnt, 16'h1);
    check_val("t3_serr_drop", serr, 1'b0);
    check_val("t3_np_cnt", np_serr_cnt, 16'h0);

    // 4: out-of-range requests are dropped; read+write performs only the write
    @(negedge clk); read = 1'b1; addr = 11'd1024; #1;
    check_val("t4_oor_mem_read", mem_read, 1'b0);
    check_val("t4_oor_mem_addr", mem_addr, 8'd0);
    @(negedge clk); read = 1'b0; write = 1'b1; addr = 11'd1500; din = 32'h1111_2222; #1;
    check_val("t4_oor_mem_write", mem_write, 1'b0);
    check_val("t4_oor_mem_bw", mem_bw, '0);
    @(negedge clk); read = 1'b1; write = 1'b1; addr = 11'd6; din = 32'hDEAD_BEEF; #1;
    check_val("t4_rw_mem_read", mem_read, 1'b0);
    check_val("t4_rw_mem_write", mem_write, 1'b1);
    check_val("t4_rw_mem_addr", mem_addr, 8'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); read = 1'b0; write = 1'b0; #1;
      check_val("t4_no_vld", rd_vld, 1'b0);
    end
    @(negedge clk); read = 1'b1; addr = 11'd6;
    @(negedge clk); read = 1'b0;
    @(negedge clk); #1;
    check_val("t4_rd_vld", rd_vld, 1'b1);
    check_val("t4_dout", dout, 32'hDEAD_BEEF);
    check_val("t4_padr", padr, 10'h201);

    // 5: reset while a read is in flight
    @(negedge clk); read = 1'b1; addr = 11'd5;
    @(negedge clk); rst_n = 1'b0; #1;
    check_val("t5_mem_read_forced", mem_read, 1'b0);
    check_val("t5_rd_vld_rst", rd_vld, 1'b0);
    @(negedge clk); rst_n = 1'b1; read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t5_rd_vld", rd_vld, 1'b0);
      check_val("t5_dout", dout, 32'h0);
      @(negedge clk);
    end
    check_val("t5_serr_cnt", serr_cnt, 16'h0);

    // 6: continuous corrupted reads drive serr_cnt into saturation
    for (int k = 0; k < 65546; k++) begin
      @(negedge clk); read = 1'b1; addr = 11'd12;
      if (k == 10) begin
        check_val("t6_serr", serr, 1'b1);
        check_val("t6_cnt_k10", serr_cnt, 16'd8);
      end
      if (k == 65536) check_val("t6_cnt_fffe", serr_cnt, 16'hFFFE);
      if (k == 65537) check_val("t6_cnt_ffff", serr_cnt, 16'hFFFF);
    end
    read = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("t6_cnt_sat", serr_cnt, 16'hFFFF);
    check_val("t6_serr_idle", serr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
